// File: rtl/coloram_pkg.sv
// Shared widths, swap-state encoding and word-width helper for the ping-pong colour memory.
package coloram_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_CHAN_W   = 8;
  localparam int DEF_NUM_CHAN = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  function automatic int word_w(input int chan_w, input int num_chan);
    return chan_w * num_chan;
  endfunction

endpackage

// File: rtl/color_frame_buffer_if.sv
// Host/serializer bus of the colour frame buffer; master is the host side, slave the buffer.
interface color_frame_buffer_if #(
  parameter int ADDR_W   = coloram_pkg::DEF_ADDR_W,
  parameter int CHAN_W   = coloram_pkg::DEF_CHAN_W,
  parameter int NUM_CHAN = coloram_pkg::DEF_NUM_CHAN
);
  import coloram_pkg::*;

  localparam int WORD_W = word_w(CHAN_W, NUM_CHAN);

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WORD_W-1:0]   wr_data;
  logic [NUM_CHAN-1:0] wr_chan_en;
  logic                swap_req;
  logic                rd_frame_sync;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic [CHAN_W-1:0]   brightness;
  logic                rd_valid;
  logic [WORD_W-1:0]   rd_data;
  logic                front_bank;
  logic                swap_pending;
  logic                swap_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_chan_en, swap_req, rd_frame_sync,
           rd_req, rd_addr, brightness,
    input  rd_valid, rd_data, front_bank, swap_pending, swap_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_chan_en, swap_req, rd_frame_sync,
           rd_req, rd_addr, brightness,
    output rd_valid, rd_data, front_bank, swap_pending, swap_done
  );

endinterface

// File: rtl/color_sdp_ram.sv
// Simple dual-port synchronous RAM with per-channel byte-lane write enables and registered read.
module color_sdp_ram
  import coloram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W + 1,
  parameter int CHAN_W   = DEF_CHAN_W,
  parameter int NUM_CHAN = DEF_NUM_CHAN
) (
  input  logic                                   clk,
  input  logic                                   wr_en,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [word_w(CHAN_W, NUM_CHAN)-1:0]    wr_data,
  input  logic [NUM_CHAN-1:0]                    wr_chan_en,
  input  logic                                   rd_en,
  input  logic [ADDR_W-1:0]                      rd_addr,
  output logic [word_w(CHAN_W, NUM_CHAN)-1:0]    rd_data
);
  localparam int WORD_W = word_w(CHAN_W, NUM_CHAN);
  localparam int DEPTH  = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NUM_CHAN; k++) begin
        if (wr_chan_en[k]) begin
          mem[wr_addr][k*CHAN_W +: CHAN_W] <= wr_data[k*CHAN_W +: CHAN_W];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/color_frame_buffer.sv
// Ping-pong LED colour memory: host fills the back bank, serializer reads the brightness-scaled
// front bank, and banks swap only on a serializer frame boundary.
module color_frame_buffer
  import coloram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CHAN_W   = DEF_CHAN_W,
  parameter int NUM_CHAN = DEF_NUM_CHAN
) (
  input  logic                 clk,
  input  logic                 rst,
  color_frame_buffer_if.slave  bus
);
  localparam int WORD_W = word_w(CHAN_W, NUM_CHAN);
  localparam int PROD_W = 2*CHAN_W + 1;

  swap_state_t       state_q, state_d;
  logic              do_swap;
  logic              front_q;
  logic              done_q;
  logic              valid1_q;
  logic [CHAN_W-1:0] bright1_q;
  logic              valid2_q;
  logic [WORD_W-1:0] data2_q;
  logic [WORD_W-1:0] ram_q;
  logic [WORD_W-1:0] scaled;
  logic [CHAN_W:0]   bscale;

  // Bank bit selects the half of the RAM: writes always go to the back bank.
  color_sdp_ram #(
    .ADDR_W   (ADDR_W + 1),
    .CHAN_W   (CHAN_W),
    .NUM_CHAN (NUM_CHAN)
  ) u_ram (
    .clk        (clk),
    .wr_en      (bus.wr_en),
    .wr_addr    ({~front_q, bus.wr_addr}),
    .wr_data    (bus.wr_data),
    .wr_chan_en (bus.wr_chan_en),
    .rd_en      (bus.rd_req),
    .rd_addr    ({front_q, bus.rd_addr}),
    .rd_data    (ram_q)
  );

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.swap_req) begin
          if (bus.rd_frame_sync) begin
            do_swap = 1'b1;
          end else begin
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (bus.rd_frame_sync) begin
          do_swap = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      front_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_q ^ do_swap;
      done_q  <= do_swap;
    end
  end

  // Brightness travels with the read so the scale stage uses the value sampled with rd_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q  <= 1'b0;
      bright1_q <= '0;
      valid2_q  <= 1'b0;
      data2_q   <= '0;
    end else begin
      valid1_q <= bus.rd_req;
      if (bus.rd_req) begin
        bright1_q <= bus.brightness;
      end
      valid2_q <= valid1_q;
      if (valid1_q) begin
        data2_q <= scaled;
      end
    end
  end

  assign bscale = {1'b0, bright1_q} + {{CHAN_W{1'b0}}, 1'b1};

  for (genvar k = 0; k < NUM_CHAN; k++) begin : g_scale
    logic [PROD_W-1:0] prod;
    assign prod = PROD_W'(ram_q[k*CHAN_W +: CHAN_W]) * PROD_W'(bscale);
    assign scaled[k*CHAN_W +: CHAN_W] = CHAN_W'(prod >> CHAN_W);
  end

  assign bus.rd_valid     = valid2_q;
  assign bus.rd_data      = data2_q;
  assign bus.front_bank   = front_q;
  assign bus.swap_pending = (state_q == PENDING);
  assign bus.swap_done    = done_q;

endmodule
